// File: rtl/rvv_pkg.sv
// rvv_pkg: RVV element-width encoding shared by the vector units.
package rvv_pkg;

   typedef enum logic [1:0] {
      EW_8  = 2'b00,
      EW_16 = 2'b01,
      EW_32 = 2'b10,
      EW_64 = 2'b11
   } vew_e;

endpackage

// File: rtl/spatz_pkg.sv
// spatz_pkg: SIMD lane operation encoding and pipeline limits.
package spatz_pkg;

   localparam int MaxSimdLatency = 4;

   // Saturating members are always enumerated; they only compute when
   // SPATZ_SIMD_SAT_EN is defined, otherwise they behave as unsupported.
   typedef enum logic [5:0] {
      VADD, VSUB, VRSUB, VADC, VSBC, VMADC, VMSBC,
      VMIN, VMINU, VMAX, VMAXU,
      VAND, VOR, VXOR,
      VSLL, VSRL, VSRA,
      VMUL, VMULH, VMULHU, VMULHSU,
      VMACC, VNMSAC, VMADD, VNMSUB,
      VMV,
      VSADD, VSADDU, VSSUB, VSSUBU
   } op_e;

endpackage

// File: rtl/spatz_simd_elem.sv
// spatz_simd_elem: combinational single-element engine of width EW.
// Saturating ops and sat_o exist only when SPATZ_SIMD_SAT_EN is defined.
module spatz_simd_elem
   import spatz_pkg::*;
#(
   parameter int EW = 8
) (
   input  op_e           operation_i,
   input  logic [EW-1:0] op_s1_i,
   input  logic [EW-1:0] op_s2_i,
   input  logic [EW-1:0] op_d_i,
   input  logic          is_signed_i,
   input  logic          carry_i,
`ifdef SPATZ_SIMD_SAT_EN
   output logic          sat_o,
`endif
   output logic [EW-1:0] result_o
);

   localparam int ShW = $clog2(EW);

   logic            add_cin;
   logic            sub_bin;
   logic [EW:0]     add_ext;
   logic [EW:0]     sub_ext;
   logic [ShW-1:0]  shamt;
   logic            lt_s;
   logic            lt_u;
   logic            min_lt;
   logic            mul_sa;
   logic            mul_sb;
   logic [2*EW-1:0] mul_a;
   logic [2*EW-1:0] mul_b;
   logic [2*EW-1:0] mul_p;
   logic [EW-1:0]   mac_p1;
   logic [EW-1:0]   mac_p2;

   assign add_cin = carry_i & ((operation_i == VADC) | (operation_i == VMADC));
   assign sub_bin = carry_i & ((operation_i == VSBC) | (operation_i == VMSBC));
   assign add_ext = {1'b0, op_s1_i} + {1'b0, op_s2_i} + {{EW{1'b0}}, add_cin};
   assign sub_ext = {1'b0, op_s1_i} - {1'b0, op_s2_i} - {{EW{1'b0}}, sub_bin};

   assign shamt  = op_s2_i[ShW-1:0];
   assign lt_s   = $signed(op_s1_i) < $signed(op_s2_i);
   assign lt_u   = op_s1_i < op_s2_i;
   assign min_lt = is_signed_i ? lt_s : lt_u;

   // Operands are sign/zero extended to 2*EW so a plain unsigned multiply
   // yields the exact signed, unsigned or mixed-sign double-width product.
   assign mul_sa = is_signed_i & (operation_i == VMULH);
   assign mul_sb = (is_signed_i & (operation_i == VMULH)) | (operation_i == VMULHSU);
   assign mul_a  = {{EW{mul_sa & op_s1_i[EW-1]}}, op_s1_i};
   assign mul_b  = {{EW{mul_sb & op_s2_i[EW-1]}}, op_s2_i};
   assign mul_p  = mul_a * mul_b;
   assign mac_p1 = op_s1_i * op_s2_i;
   assign mac_p2 = op_s1_i * op_d_i;

`ifdef SPATZ_SIMD_SAT_EN
   logic          sadd_ovf;
   logic          ssub_ovf;
   logic [EW-1:0] s_bound;

   assign sadd_ovf = (op_s1_i[EW-1] == op_s2_i[EW-1]) & (add_ext[EW-1] != op_s1_i[EW-1]);
   assign ssub_ovf = (op_s1_i[EW-1] != op_s2_i[EW-1]) & (sub_ext[EW-1] != op_s1_i[EW-1]);
   assign s_bound  = op_s1_i[EW-1] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
`endif

   always_comb begin
      result_o = '0;
`ifdef SPATZ_SIMD_SAT_EN
      sat_o    = 1'b0;
`endif
      case (operation_i)
         VADD, VADC: result_o = add_ext[EW-1:0];
         VSUB, VSBC: result_o = sub_ext[EW-1:0];
         VRSUB:      result_o = op_s2_i - op_s1_i;
         VMADC:      result_o = {{(EW-1){1'b0}}, add_ext[EW]};
         VMSBC:      result_o = {{(EW-1){1'b0}}, sub_ext[EW]};
         VMIN:       result_o = min_lt ? op_s1_i : op_s2_i;
         VMINU:      result_o = lt_u ? op_s1_i : op_s2_i;
         VMAX:       result_o = min_lt ? op_s2_i : op_s1_i;
         VMAXU:      result_o = lt_u ? op_s2_i : op_s1_i;
         VAND:       result_o = op_s1_i & op_s2_i;
         VOR:        result_o = op_s1_i | op_s2_i;
         VXOR:       result_o = op_s1_i ^ op_s2_i;
         VSLL:       result_o = op_s1_i << shamt;
         VSRL:       result_o = op_s1_i >> shamt;
         VSRA:       result_o = $signed(op_s1_i) >>> shamt;
         VMUL:       result_o = mul_p[EW-1:0];
         VMULH, VMULHU, VMULHSU: result_o = mul_p[2*EW-1:EW];
         VMACC:      result_o = op_d_i + mac_p1;
         VNMSAC:     result_o = op_d_i - mac_p1;
         VMADD:      result_o = op_s2_i + mac_p2;
         VNMSUB:     result_o = op_s2_i - mac_p2;
         VMV:        result_o = op_s1_i;
`ifdef SPATZ_SIMD_SAT_EN
         VSADD: begin
            result_o = sadd_ovf ? s_bound : add_ext[EW-1:0];
            sat_o    = sadd_ovf;
         end
         VSADDU: begin
            result_o = add_ext[EW] ? {EW{1'b1}} : add_ext[EW-1:0];
            sat_o    = add_ext[EW];
         end
         VSSUB: begin
            result_o = ssub_ovf ? s_bound : sub_ext[EW-1:0];
            sat_o    = ssub_ovf;
         end
         VSSUBU: begin
            result_o = sub_ext[EW] ? {EW{1'b0}} : sub_ext[EW-1:0];
            sat_o    = sub_ext[EW];
         end
`endif
         default:    result_o = '0;
      endcase
   end

endmodule

// File: rtl/spatz_simd_lane_pipe.sv
// spatz_simd_lane_pipe: packed-SIMD lane with an elastic Latency-stage result pipeline.
// Defining SPATZ_SIMD_SAT_EN adds saturating add/sub and the registered sat_o flag.
module spatz_simd_lane_pipe
   import spatz_pkg::*;
#(
   parameter int Width    = 64,
   parameter int Latency  = 2,
   parameter int TagWidth = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  op_e                  operation_i,
   input  logic [Width-1:0]     op_s1_i,
   input  logic [Width-1:0]     op_s2_i,
   input  logic [Width-1:0]     op_d_i,
   input  logic                 is_signed_i,
   input  logic [Width/8-1:0]   carry_i,
   input  rvv_pkg::vew_e        sew_i,
   input  logic [TagWidth-1:0]  tag_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [Width-1:0]     result_o,
`ifdef SPATZ_SIMD_SAT_EN
   output logic                 sat_o,
`endif
   output logic [TagWidth-1:0]  tag_o
);

   localparam int NumEw     = $clog2(Width / 8) + 1;
   localparam int PipeDepth = (Latency > MaxSimdLatency) ? MaxSimdLatency :
                              ((Latency < 1) ? 1 : Latency);
   localparam logic [1:0] MaxSewIdx = 2'(NumEw - 1);

   logic [1:0]                  sew_raw;
   logic [1:0]                  sew_idx;
   logic [NumEw-1:0][Width-1:0] ew_res;
   logic [Width-1:0]            comp_res;
`ifdef SPATZ_SIMD_SAT_EN
   logic [NumEw-1:0]            ew_sat;
   logic                        comp_sat;
   logic [PipeDepth-1:0]        pipe_sat;
`endif

   logic [PipeDepth-1:0]                pipe_valid;
   logic [PipeDepth-1:0][Width-1:0]     pipe_res;
   logic [PipeDepth-1:0][TagWidth-1:0]  pipe_tag;
   logic [PipeDepth-1:0]                advance;
   logic [PipeDepth-1:0]                load;

   // Element widths wider than the datapath collapse to one Width-bit element.
   assign sew_raw = sew_i;
   assign sew_idx = (sew_raw > MaxSewIdx) ? MaxSewIdx : sew_raw;

   for (genvar e = 0; e < NumEw; e++) begin : g_ew
      localparam int Ew    = 8 << e;
      localparam int NumEl = Width / Ew;
`ifdef SPATZ_SIMD_SAT_EN
      logic [NumEl-1:0] sat_el;
      assign ew_sat[e] = |sat_el;
`endif
      for (genvar j = 0; j < NumEl; j++) begin : g_el
         spatz_simd_elem #(.EW(Ew)) u_elem (
            .operation_i (operation_i),
            .op_s1_i     (op_s1_i[j*Ew +: Ew]),
            .op_s2_i     (op_s2_i[j*Ew +: Ew]),
            .op_d_i      (op_d_i[j*Ew +: Ew]),
            .is_signed_i (is_signed_i),
            .carry_i     (carry_i[j]),
`ifdef SPATZ_SIMD_SAT_EN
            .sat_o       (sat_el[j]),
`endif
            .result_o    (ew_res[e][j*Ew +: Ew])
         );
      end
   end

   always_comb begin
      comp_res = '0;
`ifdef SPATZ_SIMD_SAT_EN
      comp_sat = 1'b0;
`endif
      for (int e = 0; e < NumEw; e++) begin
         if (sew_idx == 2'(e)) begin
            comp_res = ew_res[e];
`ifdef SPATZ_SIMD_SAT_EN
            comp_sat = ew_sat[e];
`endif
         end
      end
   end

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready, and a presented result (with its
   // tag) stays unchanged until it is taken. A stage loads when it is empty or
   // its current content moves on in the same cycle, so bubbles collapse.
   always_comb begin
      advance = '0;
      advance[PipeDepth-1] = ready_i;
      for (int k = PipeDepth - 2; k >= 0; k--) begin
         advance[k] = ~pipe_valid[k+1] | advance[k+1];
      end
      load = ~pipe_valid | advance;
   end

   assign ready_o = load[0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pipe_valid <= '0;
         pipe_res   <= '0;
         pipe_tag   <= '0;
`ifdef SPATZ_SIMD_SAT_EN
         pipe_sat   <= '0;
`endif
      end else begin
         if (load[0]) begin
            pipe_valid[0] <= valid_i;
            if (valid_i) begin
               pipe_res[0] <= comp_res;
               pipe_tag[0] <= tag_i;
`ifdef SPATZ_SIMD_SAT_EN
               pipe_sat[0] <= comp_sat;
`endif
            end
         end
         for (int k = 1; k < PipeDepth; k++) begin
            if (load[k]) begin
               pipe_valid[k] <= pipe_valid[k-1];
               if (pipe_valid[k-1]) begin
                  pipe_res[k] <= pipe_res[k-1];
                  pipe_tag[k] <= pipe_tag[k-1];
`ifdef SPATZ_SIMD_SAT_EN
                  pipe_sat[k] <= pipe_sat[k-1];
`endif
               end
            end
         end
      end
   end

   assign valid_o  = pipe_valid[PipeDepth-1];
   assign result_o = pipe_res[PipeDepth-1];
   assign tag_o    = pipe_tag[PipeDepth-1];
`ifdef SPATZ_SIMD_SAT_EN
   assign sat_o    = pipe_sat[PipeDepth-1];
`endif

endmodule

// File: tb/tb_spatz_simd_lane_pipe.sv
// tb_spatz_simd_lane_pipe: directed self-checking bench, Width=64 Latency=2.
// Saturation vectors are checked when SPATZ_SIMD_SAT_EN is defined.
module tb_spatz_simd_lane_pipe;
   import spatz_pkg::*;
   import rvv_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        valid_i;
   logic        ready_o;
   op_e         operation_i;
   logic [63:0] op_s1_i;
   logic [63:0] op_s2_i;
   logic [63:0] op_d_i;
   logic        is_signed_i;
   logic [7:0]  carry_i;
   vew_e        sew_i;
   logic [3:0]  tag_i;
   logic        valid_o;
   logic        ready_i;
   logic [63:0] result_o;
   logic [3:0]  tag_o;
`ifdef SPATZ_SIMD_SAT_EN
   logic        sat_o;
`endif

   int n_total = 0;
   int n_bad   = 0;
   int stalls  = 0;

   logic [63:0] exp_res_q[$];
   logic [3:0]  exp_tag_q[$];
   logic        exp_sat_q[$];

   spatz_simd_lane_pipe #(.Width(64), .Latency(2), .TagWidth(4)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .operation_i (operation_i),
      .op_s1_i     (op_s1_i),
      .op_s2_i     (op_s2_i),
      .op_d_i      (op_d_i),
      .is_signed_i (is_signed_i),
      .carry_i     (carry_i),
      .sew_i       (sew_i),
      .tag_i       (tag_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .result_o    (result_o),
`ifdef SPATZ_SIMD_SAT_EN
      .sat_o       (sat_o),
`endif
      .tag_o       (tag_o)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   // driver tasks
   task automatic present(input op_e op, input logic [63:0] s1, input logic [63:0] s2,
                          input logic [63:0] d, input logic sg, input logic [7:0] cin,
                          input vew_e sew, input logic [3:0] tg);
      valid_i     = 1'b1;
      operation_i = op;
      op_s1_i     = s1;
      op_s2_i     = s2;
      op_d_i      = d;
      is_signed_i = sg;
      carry_i     = cin;
      sew_i       = sew;
      tag_i       = tg;
   endtask

   task automatic push_exp(input logic [63:0] r, input logic [3:0] tg, input logic s);
      exp_res_q.push_back(r);
      exp_tag_q.push_back(tg);
      exp_sat_q.push_back(s);
   endtask

   // Presents an op and waits (bounded) for its acceptance; returns just after that edge.
   task automatic send(input op_e op, input logic [63:0] s1, input logic [63:0] s2,
                       input logic [63:0] d, input logic sg, input logic [7:0] cin,
                       input vew_e sew, input logic [3:0] tg,
                       input logic [63:0] exp_r, input logic exp_s);
      logic accepted;
      accepted = 1'b0;
      present(op, s1, s2, d, sg, cin, sew, tg);
      for (int c = 0; c < 64 && !accepted; c++) begin
         @(negedge clk);
         if (ready_o) begin
            accepted = 1'b1;
            push_exp(exp_r, tg, exp_s);
         end else begin
            stalls++;
         end
         @(posedge clk);
         #1;
      end
      if (!accepted) begin
         n_total++;
         n_bad++;
         $error("FAIL send_timeout tag=%h observed=not_accepted expected=accepted", tg);
      end
   endtask

   task automatic drain();
      int c;
      c = 0;
      valid_i = 1'b0;
      while (exp_res_q.size() > 0 && c < 100) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("drain_empty", 64'(exp_res_q.size()), 64'd0);
   endtask

   // scoreboard: every output transfer is matched against the expected queue
   always @(negedge clk) begin
      logic [63:0] er;
      logic [3:0]  et;
      logic        es;
      if (rst_n && valid_o && ready_i) begin
         n_total++;
         assert (exp_res_q.size() > 0) else begin
            n_bad++;
            $error("FAIL out_unexpected observed_tag=%h observed_result=%h expected=none", tag_o, result_o);
         end
         if (exp_res_q.size() > 0) begin
            er = exp_res_q.pop_front();
            et = exp_tag_q.pop_front();
            es = exp_sat_q.pop_front();
            check($sformatf("out_tag_t%0h", et), 64'(tag_o), 64'(et));
            check($sformatf("out_result_t%0h", et), result_o, er);
`ifdef SPATZ_SIMD_SAT_EN
            check($sformatf("out_sat_t%0h", et), 64'(sat_o), 64'(es));
`else
            if (es !== 1'b0) $display("note: sat expectation ignored for tag %0h", et);
`endif
         end
      end
   end

   initial begin
      rst_n       = 1'b0;
      valid_i     = 1'b0;
      ready_i     = 1'b1;
      operation_i = VADD;
      op_s1_i     = '0;
      op_s2_i     = '0;
      op_d_i      = '0;
      is_signed_i = 1'b0;
      carry_i     = '0;
      sew_i       = EW_8;
      tag_i       = '0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid_o", 64'(valid_o), 64'd0);
      check("rst_result_o", result_o, 64'd0);
      check("rst_tag_o", 64'(tag_o), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready_o", 64'(ready_o), 64'd1);
      @(posedge clk);
      #1;

      // first op: latency of exactly two cycles
      send(VADD, 64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 64'h0, 1'b0, 8'h00, EW_8, 4'h1,
           64'h0, 1'b0);
      valid_i = 1'b0;
      @(negedge clk);
      check("lat_t1_valid", 64'(valid_o), 64'd0);
      @(negedge clk);
      check("lat_t2_valid", 64'(valid_o), 64'd1);
      check("lat_t2_tag", 64'(tag_o), 64'h1);
      @(posedge clk);
      #1;

      // back-to-back burst of directed vectors
      stalls = 0;
      send(VMULH,   64'h8000, 64'h8000, 64'h0, 1'b1, 8'h00, EW_16, 4'h2, 64'h4000, 1'b0);
      send(VMULHSU, 64'h8000, 64'h8000, 64'h0, 1'b1, 8'h00, EW_16, 4'h3, 64'hC000, 1'b0);
      send(VMADC, 64'h0000_0001_FFFF_FFFF, 64'h1, 64'h0, 1'b0, 8'h02, EW_32, 4'h4, 64'h1, 1'b0);
      send(VSRA, 64'h8000_0000, 64'd31, 64'h0, 1'b0, 8'h00, EW_32, 4'h5,
           64'h0000_0000_FFFF_FFFF, 1'b0);
      send(VSUB, 64'h0, 64'h1, 64'h0, 1'b0, 8'h00, EW_8, 4'h6, 64'hFF, 1'b0);
      send(VSLL, 64'h0001_0001_0001_8001, 64'h0000_0010_0004_0011, 64'h0, 1'b0, 8'h00, EW_16,
           4'h7, 64'h0001_0001_0010_0002, 1'b0);
      send(VMACC, 64'd3, 64'd4, 64'd10, 1'b0, 8'h00, EW_64, 4'h8, 64'd22, 1'b0);
      send(VNMSUB, 64'h02, 64'h05, 64'h03, 1'b0, 8'h00, EW_8, 4'h9, 64'hFF, 1'b0);
      send(VMIN, 64'h80, 64'h01, 64'h0, 1'b1, 8'h00, EW_8, 4'hA, 64'h80, 1'b0);
      send(VMINU, 64'h80, 64'h01, 64'h0, 1'b0, 8'h00, EW_8, 4'hB, 64'h01, 1'b0);
      send(VMSBC, 64'h0, 64'h0, 64'h0, 1'b0, 8'h01, EW_16, 4'hC, 64'h1, 1'b0);
      send(VADC, 64'h10, 64'h0, 64'h0, 1'b0, 8'h03, EW_8, 4'hD, 64'h0111, 1'b0);
      send(VMV, 64'h1234_5678_9ABC_DEF0, 64'h0, 64'h0, 1'b0, 8'h00, EW_32, 4'hE,
           64'h1234_5678_9ABC_DEF0, 1'b0);
`ifdef SPATZ_SIMD_SAT_EN
      send(VSADD, 64'h7F, 64'h01, 64'h0, 1'b1, 8'h00, EW_8, 4'hF, 64'h7F, 1'b1);
      send(VSSUBU, 64'h00, 64'h01, 64'h0, 1'b0, 8'h00, EW_8, 4'h0, 64'h00, 1'b1);
      send(VSADDU, 64'h10, 64'h01, 64'h0, 1'b0, 8'h00, EW_8, 4'h1, 64'h11, 1'b0);
`else
      send(VSADD, 64'h7F, 64'h01, 64'h0, 1'b1, 8'h00, EW_8, 4'hF, 64'h0, 1'b0);
`endif
      check("burst_no_stall", 64'(stalls), 64'd0);
      drain();

      // backpressure: two ops fill the pipe, the third is held off
      ready_i = 1'b0;
      send(VAND, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0, 1'b0, 8'h00, EW_8,
           4'h1, 64'h0F00_0F00_0F00_0F00, 1'b0);
      send(VOR, 64'hA0, 64'h05, 64'h0, 1'b0, 8'h00, EW_8, 4'h2, 64'hA5, 1'b0);
      present(VXOR, 64'hFFFF, 64'h0F0F, 64'h0, 1'b0, 8'h00, EW_16, 4'h3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_ready_low", 64'(ready_o), 64'd0);
         check("bp_valid_held", 64'(valid_o), 64'd1);
         check("bp_tag_held", 64'(tag_o), 64'h1);
         check("bp_result_held", result_o, 64'h0F00_0F00_0F00_0F00);
      end
      @(posedge clk);
      #1;
      ready_i = 1'b1;
      @(negedge clk);
      check("bp_release_ready", 64'(ready_o), 64'd1);
      check("bp_order_0", 64'(tag_o), 64'h1);
      push_exp(64'hF0F0, 4'h3, 1'b0);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      @(negedge clk);
      check("bp_order_1_valid", 64'(valid_o), 64'd1);
      check("bp_order_1", 64'(tag_o), 64'h2);
      @(negedge clk);
      check("bp_order_2_valid", 64'(valid_o), 64'd1);
      check("bp_order_2", 64'(tag_o), 64'h3);
      @(posedge clk);
      #1;
      drain();

      // reset with two ops in flight
      send(VXOR, 64'h1, 64'h2, 64'h0, 1'b0, 8'h00, EW_8, 4'h6, 64'h3, 1'b0);
      send(VXOR, 64'h4, 64'h8, 64'h0, 1'b0, 8'h00, EW_8, 4'h7, 64'hC, 1'b0);
      check("rst_inflight_valid", 64'(valid_o), 64'd1);
      rst_n   = 1'b0;
      valid_i = 1'b0;
      #1;
      check("rst_async_valid_o", 64'(valid_o), 64'd0);
      check("rst_async_result_o", result_o, 64'd0);
      check("rst_async_tag_o", 64'(tag_o), 64'd0);
      exp_res_q.delete();
      exp_tag_q.delete();
      exp_sat_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst2_ready_o", 64'(ready_o), 64'd1);
      for (int i = 0; i < 4; i++) begin
         check("rst2_no_stale", 64'(valid_o), 64'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      send(VRSUB, 64'h01, 64'h05, 64'h0, 1'b0, 8'h00, EW_8, 4'h9, 64'h04, 1'b0);
      send(VMAXU, 64'h80, 64'h01, 64'h0, 1'b0, 8'h00, EW_8, 4'hA, 64'h80, 1'b0);
      drain();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
